vdp_io_gate: RTL
================

# vdp_io_gate

Parametrised I/O front end for video-class peripherals on the MSX CPU bus: decodes up to CHANNELS io_device windows, issues one request per CPU I/O cycle to the selected device core, and stretches the CPU cycle with a wait until the core acknowledges or a timeout expires. It holds read data stable for the whole I/O cycle and aggregates masked, per-channel interrupts into one line. It replaces the ad-hoc per-device chip-select/readback/interrupt glue with one shared, multi-channel block.

## Interface
- CHANNELS, 3, number of io_device windows and device cores served (1..8)
- DATA_W, 8, CPU data width
- ACK_TIMEOUT, 15, cycles in WAIT_ACK before forced completion (1..255)
- clk  in  1  system clock (cpu_bus clock domain)
- reset_n  in  1  reset; asynchronous, active-low
- cpu_addr  in  8  CPU I/O address [7:0]
- cpu_data  in  DATA_W  CPU write data
- cpu_req  in  1  single-cycle request strobe for the current bus cycle
- cpu_wr  in  1  1 = write, sampled with cpu_req
- cpu_iorq  in  1  I/O cycle active (level)
- cpu_m1  in  1  M1 cycle; iorq with m1 is an interrupt acknowledge, never decoded
- io_device  in  CHANNELS x MSX::io_device_t  per-channel enable, mask, port
- dev_req  out  CHANNELS  one-cycle request to the selected core
- dev_wr  out  1  write flag, valid with dev_req
- dev_addr  out  8  latched CPU address
- dev_wdata  out  DATA_W  latched write data
- dev_ack  in  CHANNELS  one-cycle completion from each core
- dev_q  in  CHANNELS x DATA_W  read data, valid with dev_ack
- dev_int  in  CHANNELS  level interrupt from each core
- data  out  DATA_W  read data to CPU; all ones when not driving
- wait_n  out  1  0 = stretch CPU cycle
- interrupt  out  1  OR of enabled channel interrupts
- timeout_flag  out  CHANNELS  sticky, set per channel on timeout

## Operation
- Match per channel: enable && ((cpu_addr & mask) == port) && cpu_iorq && ~cpu_m1. Several matches: lowest index wins.
- FSM states: IDLE, ISSUE, WAIT_ACK, HOLD.
- IDLE: cpu_req with a match latches channel, addr, wr, wdata -> ISSUE. cpu_req with no match stays in IDLE and does not stretch the cycle.
- ISSUE: dev_req[ch]=1 for exactly one cycle, dev_wr/dev_addr/dev_wdata valid -> WAIT_ACK; timeout counter cleared.
- WAIT_ACK: dev_ack[ch] -> HOLD, capturing dev_q[ch] on reads. Counter reaching ACK_TIMEOUT -> HOLD with read data all ones and timeout_flag[ch] set. io_device[ch].enable dropping -> HOLD with all ones, flag not set. Acks from other channels are ignored.
- HOLD: data = captured value on reads, all ones on writes. Stay until cpu_iorq=0, then -> IDLE.
- cpu_req in any non-IDLE state is ignored; no queueing.
- cpu_iorq dropping during ISSUE/WAIT_ACK: the transaction still completes in the core; the FSM goes directly to IDLE on ack/timeout.
- timeout_flag[ch] clears when a later transaction on ch completes by ack.
- interrupt = |(dev_int & enables), registered.

## Timing
- Reset (async, any state): FSM IDLE; dev_req 0, dev_wr 0, dev_addr 0, dev_wdata 0, data all ones, wait_n 1, interrupt 0, timeout_flag 0, counter 0.
- wait_n is combinational 0 in the cycle cpu_req matches, and registered 0 through ISSUE and WAIT_ACK. It returns to 1 in the first HOLD cycle.
- Minimum latency: cpu_req at cycle 0 -> dev_req at 1 -> ack earliest at 2 -> data valid and wait_n=1 at 3.
- Timeout: wait_n releases ACK_TIMEOUT+2 cycles after cpu_req.
- dev_ack in the same cycle as the counter reaching ACK_TIMEOUT: ack wins, flag not set.
- interrupt lags dev_int/enable by 1 cycle.
- data is registered and changes only on entering HOLD or IDLE.

## Structure
- MSX::io_device_t is reused from the shared MSX package. Add to the package: the FSM state enum vdp_io_gate_state_t and a constant IO_IDLE_DATA = all ones.
- One sub-module, io_port_match: pure per-channel decode plus a lowest-index priority encoder producing hit and channel index. Everything else stays in the top level.

## Test plan
- Read ch1 (port 0x98, mask 0xFE), core acks 2 cycles after dev_req with 0x5A -> one dev_req[1] pulse; data=0x5A and wait_n=1 from the ack+1 cycle until iorq drops.
- Write 0x3C to ch0, ack immediate -> dev_wr=1, dev_wdata=0x3C; data stays 0xFF.
- No ack, ACK_TIMEOUT=15 -> wait_n low for 17 cycles; data=0xFF; timeout_flag[ch]=1. A later acked access clears the flag.
- Overlapping windows on ch0/ch2 -> only dev_req[0] pulses. A second cpu_req during WAIT_ACK -> no new dev_req.
- dev_int=3'b101 with enables 3'b001 -> interrupt=1 one cycle later. Clear enable[0] -> interrupt=0.
- Assert reset_n=0 in WAIT_ACK -> all outputs take reset values immediately; after release, the next access works normally.

Source files
------------

// File: rtl/MSX.sv
// Shared MSX bus types: io_device window descriptor, vdp_io_gate FSM encoding
// and the idle value of the CPU read bus.
package MSX;

  typedef struct packed {
    logic       enable;
    logic [7:0] mask;
    logic [7:0] port;
  } io_device_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } vdp_io_gate_state_t;

  // Undriven CPU data bus reads as all ones; sliced to the data width at use.
  localparam logic [31:0] IO_IDLE_DATA = '1;

endpackage

// File: rtl/io_port_match.sv
// Per-channel io_device window decode with lowest-index priority select.
// Purely combinational; interrupt-acknowledge cycles (iorq with m1) never match.
module io_port_match
  import MSX::*;
#(
  parameter int CHANNELS = 3,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [7:0]                 cpu_addr,
  input  logic                       cpu_iorq,
  input  logic                       cpu_m1,
  input  io_device_t [CHANNELS-1:0]  io_device,
  output logic                       hit,
  output logic [CH_W-1:0]            ch
);

  logic [CHANNELS-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      match[i] = io_device[i].enable
              && ((cpu_addr & io_device[i].mask) == io_device[i].port)
              && cpu_iorq && !cpu_m1;
    end
  end

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    ch  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        ch  = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/vdp_io_gate.sv
// Multi-channel MSX I/O front end: decode, one request per I/O cycle, wait-state
// stretch until ack or timeout, read data held through HOLD, masked interrupt OR.
module vdp_io_gate
  import MSX::*;
#(
  parameter int CHANNELS    = 3,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       cpu_addr,
  input  logic [DATA_W-1:0]                cpu_data,
  input  logic                             cpu_req,
  input  logic                             cpu_wr,
  input  logic                             cpu_iorq,
  input  logic                             cpu_m1,
  input  io_device_t [CHANNELS-1:0]        io_device,
  output logic [CHANNELS-1:0]              dev_req,
  output logic                             dev_wr,
  output logic [7:0]                       dev_addr,
  output logic [DATA_W-1:0]                dev_wdata,
  input  logic [CHANNELS-1:0]              dev_ack,
  input  logic [CHANNELS-1:0][DATA_W-1:0]  dev_q,
  input  logic [CHANNELS-1:0]              dev_int,
  output logic [DATA_W-1:0]                data,
  output logic                             wait_n,
  output logic                             interrupt,
  output logic [CHANNELS-1:0]              timeout_flag
);

  localparam int                CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DATA_W-1:0] ONES = IO_IDLE_DATA[DATA_W-1:0];
  localparam logic [7:0]        LAST_WAIT_CNT = 8'(ACK_TIMEOUT - 1);

  vdp_io_gate_state_t state_q, state_d;

  logic              hit;
  logic [CH_W-1:0]   hit_ch;
  logic [CH_W-1:0]   ch_q;
  logic [7:0]        cnt_q;
  logic              orphan_q;
  logic              accept;
  logic              sel_ack;
  logic              sel_en;
  logic [DATA_W-1:0] sel_q;
  logic              timeout_hit;
  logic              done;
  logic              iorq_gone;
  logic [CHANNELS-1:0] enables;

  io_port_match #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_match (
    .cpu_addr  (cpu_addr),
    .cpu_iorq  (cpu_iorq),
    .cpu_m1    (cpu_m1),
    .io_device (io_device),
    .hit       (hit),
    .ch        (hit_ch)
  );

  assign accept      = (state_q == IDLE) && cpu_req && hit;
  assign sel_ack     = dev_ack[ch_q];
  assign sel_en      = io_device[ch_q].enable;
  assign sel_q       = dev_q[ch_q];
  assign timeout_hit = (cnt_q == LAST_WAIT_CNT);
  assign done        = sel_ack || timeout_hit || !sel_en;
  // A CPU that abandoned the cycle gets no HOLD phase; the core still finishes.
  assign iorq_gone   = orphan_q || !cpu_iorq;

  always_comb begin
    enables = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      enables[i] = io_device[i].enable;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (done) state_d = iorq_gone ? IDLE : HOLD;
      HOLD:     if (!cpu_iorq) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dev_req = '0;
    wait_n  = 1'b1;
    unique case (state_q)
      IDLE:     wait_n = !accept;
      ISSUE: begin
        dev_req[ch_q] = 1'b1;
        wait_n        = 1'b0;
      end
      WAIT_ACK: wait_n = 1'b0;
      HOLD:     wait_n = 1'b1;
      default:  wait_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q      <= '0;
      dev_wr    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
    end else if (accept) begin
      ch_q      <= hit_ch;
      dev_wr    <= cpu_wr;
      dev_addr  <= cpu_addr;
      dev_wdata <= cpu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_ACK) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      orphan_q <= 1'b0;
    end else if (accept) begin
      orphan_q <= 1'b0;
    end else if ((state_q == ISSUE || state_q == WAIT_ACK) && !cpu_iorq) begin
      orphan_q <= 1'b1;
    end
  end

  // Read data only moves on HOLD entry (capture) or IDLE entry (release).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= ONES;
    end else if (state_q == WAIT_ACK && done) begin
      data <= (!iorq_gone && !dev_wr && sel_ack) ? sel_q : ONES;
    end else if (state_q == HOLD && !cpu_iorq) begin
      data <= ONES;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_flag <= '0;
    end else if (state_q == WAIT_ACK) begin
      if (sel_ack) begin
        timeout_flag[ch_q] <= 1'b0;
      end else if (timeout_hit) begin
        timeout_flag[ch_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= |(dev_int & enables);
    end
  end

endmodule
